simt_register_file: RTL and testbench

- Per-core register file serving all THREADS lanes of a block in one instance.
- Each lane holds NUM_REGS registers of DATA_BITS. The top three are read-only: %blockIdx, %blockDim and %threadIdx.
- Adds four capabilities to the per-thread register file: a lane mask, a latched block ID, a multi-cycle clear sequencer for kernel relaunch, and a sticky flag for illegal writes to read-only registers.
- Sits between the decoder/scheduler and the per-lane ALU/LSU/FMA/ACT units.

---
 rtl/simt_register_file_if.sv | 47 ++++
 rtl/simt_register_file.sv | 149 ++++++++++++++
 tb/tb_simt_register_file.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simt_register_file_if.sv
// Decoder/scheduler-facing bundle of the SIMT register file: lane mask, block dispatch,
// clear control, decoded operand fields, per-lane unit results and registered operands.
interface simt_register_file_if #(
    parameter int THREADS       = 4,
    parameter int DATA_BITS     = 16,
    parameter int NUM_REGS      = 16,
    parameter int IMM_BITS      = 8,
    parameter int BLOCK_ID_BITS = 8
);
    localparam int AW = $clog2(NUM_REGS);

    logic [THREADS-1:0]           enable_mask;
    logic                         block_valid;
    logic [BLOCK_ID_BITS-1:0]     block_id;
    logic                         clear_start;
    logic                         clear_busy;
    logic [2:0]                   core_state;
    logic [AW-1:0]                decoded_rd_address;
    logic [AW-1:0]                decoded_rs_address;
    logic [AW-1:0]                decoded_rt_address;
    logic                         decoded_reg_write_enable;
    logic [2:0]                   decoded_reg_input_mux;
    logic [IMM_BITS-1:0]          decoded_immediate;
    logic [THREADS*DATA_BITS-1:0] alu_out;
    logic [THREADS*DATA_BITS-1:0] lsu_out;
    logic [THREADS*DATA_BITS-1:0] fma_out;
    logic [THREADS*DATA_BITS-1:0] act_out;
    logic [THREADS*DATA_BITS-1:0] rs;
    logic [THREADS*DATA_BITS-1:0] rt;
    logic                         ro_write_err;

    modport master (
        output enable_mask, block_valid, block_id, clear_start, core_state,
               decoded_rd_address, decoded_rs_address, decoded_rt_address,
               decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
               alu_out, lsu_out, fma_out, act_out,
        input  clear_busy, rs, rt, ro_write_err
    );

    modport slave (
        input  enable_mask, block_valid, block_id, clear_start, core_state,
               decoded_rd_address, decoded_rs_address, decoded_rt_address,
               decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
               alu_out, lsu_out, fma_out, act_out,
        output clear_busy, rs, rt, ro_write_err
    );
endinterface

// File: rtl/simt_register_file.sv
// Per-core SIMT register file: THREADS lanes of NUM_REGS registers, the top three read-only
// (%blockIdx, %blockDim, %threadIdx), with lane masking, a clear sweep and a sticky RO-write flag.
module simt_register_file #(
    parameter int THREADS       = 4,
    parameter int DATA_BITS     = 16,
    parameter int NUM_REGS      = 16,
    parameter int IMM_BITS      = 8,
    parameter int BLOCK_ID_BITS = 8
) (
    input logic                  clk,
    input logic                  reset,
    simt_register_file_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int GP = NUM_REGS - 3;

    localparam logic [AW:0]   GP_EXT   = (AW+1)'(GP);
    localparam logic [AW-1:0] A_BIDX   = AW'(GP);
    localparam logic [AW-1:0] A_BDIM   = AW'(GP + 1);
    localparam logic [AW-1:0] A_TIDX   = AW'(GP + 2);
    localparam logic [AW-1:0] IDX_LAST = AW'(GP - 1);

    typedef enum logic [2:0] {
        CS_REQUEST = 3'b011,
        CS_UPDATE  = 3'b110
    } core_state_e;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } fsm_e;

    fsm_e                         r_state;
    logic [AW-1:0]                r_idx;
    logic                         r_clear_busy;
    logic                         r_ro_err;
    logic [BLOCK_ID_BITS-1:0]     r_block_idx;
    logic [DATA_BITS-1:0]         r_gpr [THREADS][GP];
    logic [THREADS*DATA_BITS-1:0] r_rs;
    logic [THREADS*DATA_BITS-1:0] r_rt;

    logic [DATA_BITS-1:0]         w_imm_ext;
    logic [DATA_BITS-1:0]         w_wdata  [THREADS];
    logic [DATA_BITS-1:0]         w_rs_val [THREADS];
    logic [DATA_BITS-1:0]         w_rt_val [THREADS];
    logic                         w_rd_is_gp;
    logic                         w_rs_is_gp;
    logic                         w_rt_is_gp;
    logic                         w_request;
    logic                         w_update;

    assign w_imm_ext  = DATA_BITS'($signed(bus.decoded_immediate));
    assign w_rd_is_gp = {1'b0, bus.decoded_rd_address} < GP_EXT;
    assign w_rs_is_gp = {1'b0, bus.decoded_rs_address} < GP_EXT;
    assign w_rt_is_gp = {1'b0, bus.decoded_rt_address} < GP_EXT;
    assign w_request  = bus.core_state == CS_REQUEST;
    assign w_update   = (bus.core_state == CS_UPDATE) && bus.decoded_reg_write_enable;

    always_comb begin
        for (int unsigned i = 0; i < THREADS; i++) begin
            case (bus.decoded_reg_input_mux)
                3'b001:  w_wdata[i] = bus.lsu_out[i*DATA_BITS +: DATA_BITS];
                3'b010:  w_wdata[i] = w_imm_ext;
                3'b011:  w_wdata[i] = bus.fma_out[i*DATA_BITS +: DATA_BITS];
                3'b100:  w_wdata[i] = bus.act_out[i*DATA_BITS +: DATA_BITS];
                default: w_wdata[i] = bus.alu_out[i*DATA_BITS +: DATA_BITS];
            endcase
        end
    end

    // Read-only registers are synthesised from constants and the shared block ID latch.
    always_comb begin
        for (int unsigned i = 0; i < THREADS; i++) begin
            w_rs_val[i] = '0;
            if (w_rs_is_gp)                             w_rs_val[i] = r_gpr[i][bus.decoded_rs_address];
            else if (bus.decoded_rs_address == A_BIDX)  w_rs_val[i] = DATA_BITS'(r_block_idx);
            else if (bus.decoded_rs_address == A_BDIM)  w_rs_val[i] = DATA_BITS'(THREADS);
            else if (bus.decoded_rs_address == A_TIDX)  w_rs_val[i] = DATA_BITS'(i);

            w_rt_val[i] = '0;
            if (w_rt_is_gp)                             w_rt_val[i] = r_gpr[i][bus.decoded_rt_address];
            else if (bus.decoded_rt_address == A_BIDX)  w_rt_val[i] = DATA_BITS'(r_block_idx);
            else if (bus.decoded_rt_address == A_BDIM)  w_rt_val[i] = DATA_BITS'(THREADS);
            else if (bus.decoded_rt_address == A_TIDX)  w_rt_val[i] = DATA_BITS'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_clear_busy <= 1'b0;
            r_ro_err     <= 1'b0;
            r_block_idx  <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            for (int unsigned i = 0; i < THREADS; i++)
                for (int unsigned j = 0; j < GP; j++)
                    r_gpr[i][j] <= '0;
        end else begin
            if (bus.block_valid)
                r_block_idx <= bus.block_id;

            case (r_state)
                S_IDLE: begin
                    if (w_request) begin
                        for (int unsigned i = 0; i < THREADS; i++) begin
                            if (bus.enable_mask[i]) begin
                                r_rs[i*DATA_BITS +: DATA_BITS] <= w_rs_val[i];
                                r_rt[i*DATA_BITS +: DATA_BITS] <= w_rt_val[i];
                            end
                        end
                    end else if (w_update) begin
                        if (w_rd_is_gp) begin
                            for (int unsigned i = 0; i < THREADS; i++)
                                if (bus.enable_mask[i])
                                    r_gpr[i][bus.decoded_rd_address] <= w_wdata[i];
                        end else if (|bus.enable_mask) begin
                            r_ro_err <= 1'b1;
                        end
                    end
                    // Starting a sweep clears the flag even if this cycle also set it.
                    if (bus.clear_start) begin
                        r_state      <= S_CLEAR;
                        r_idx        <= '0;
                        r_clear_busy <= 1'b1;
                        r_ro_err     <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    for (int unsigned i = 0; i < THREADS; i++)
                        r_gpr[i][r_idx] <= '0;
                    if (r_idx == IDX_LAST) begin
                        r_state      <= S_IDLE;
                        r_clear_busy <= 1'b0;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rs           = r_rs;
    assign bus.rt           = r_rt;
    assign bus.clear_busy   = r_clear_busy;
    assign bus.ro_write_err = r_ro_err;
endmodule

// File: tb/tb_simt_register_file.sv
// Self-checking bench for simt_register_file: directed vector table, hand-written clear/reset
// sequences and randomized traffic compared against a lane/register array model.
module tb_simt_register_file;
    localparam int T  = 4;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam int IW = 8;
    localparam int BW = 8;
    localparam int GP = NR - 3;

    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;

    logic clk;
    logic reset;

    simt_register_file_if #(.THREADS(T), .DATA_BITS(DW), .NUM_REGS(NR),
                            .IMM_BITS(IW), .BLOCK_ID_BITS(BW)) bus ();

    simt_register_file #(.THREADS(T), .DATA_BITS(DW), .NUM_REGS(NR),
                         .IMM_BITS(IW), .BLOCK_ID_BITS(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;

    // Reference model: plain arrays indexed by lane and register number.
    logic [DW-1:0] m_gpr [T][GP];
    logic [DW-1:0] m_rs  [T];
    logic [DW-1:0] m_rt  [T];
    logic [BW-1:0] m_bidx;
    logic          m_err;
    int            m_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < T; l++) begin
            m_rs[l] = '0;
            m_rt[l] = '0;
            for (int r = 0; r < GP; r++) m_gpr[l][r] = '0;
        end
        m_bidx = '0;
        m_err  = 1'b0;
        m_left = 0;
    endtask

    function automatic logic [DW-1:0] m_read(input int lane, input int addr);
        if (addr < GP)          return m_gpr[lane][addr];
        else if (addr == GP)    return DW'(m_bidx);
        else if (addr == GP+1)  return DW'(T);
        else                    return DW'(lane);
    endfunction

    function automatic logic [DW-1:0] m_src(input int lane);
        logic [DW-1:0] imm;
        imm = DW'(bus.decoded_immediate);
        if (bus.decoded_immediate[IW-1]) imm = imm + 16'hFF00;
        case (bus.decoded_reg_input_mux)
            3'd1:    return bus.lsu_out[lane*DW +: DW];
            3'd2:    return imm;
            3'd3:    return bus.fma_out[lane*DW +: DW];
            3'd4:    return bus.act_out[lane*DW +: DW];
            default: return bus.alu_out[lane*DW +: DW];
        endcase
    endfunction

    function automatic logic [63:0] m_pack(input int which);
        logic [63:0] v;
        v = '0;
        for (int l = 0; l < T; l++) v[l*DW +: DW] = (which == 0) ? m_rs[l] : m_rt[l];
        return v;
    endfunction

    task automatic model_step();
        if (m_left > 0) begin
            for (int l = 0; l < T; l++) m_gpr[l][GP - m_left] = '0;
            m_left--;
        end else begin
            if (bus.core_state == REQ) begin
                for (int l = 0; l < T; l++)
                    if (bus.enable_mask[l]) begin
                        m_rs[l] = m_read(l, int'(bus.decoded_rs_address));
                        m_rt[l] = m_read(l, int'(bus.decoded_rt_address));
                    end
            end else if (bus.core_state == UPD && bus.decoded_reg_write_enable) begin
                if (int'(bus.decoded_rd_address) < GP) begin
                    for (int l = 0; l < T; l++)
                        if (bus.enable_mask[l]) m_gpr[l][bus.decoded_rd_address] = m_src(l);
                end else if (bus.enable_mask != 0) begin
                    m_err = 1'b1;
                end
            end
            if (bus.clear_start) begin
                m_left = GP;
                m_err  = 1'b0;
            end
        end
        if (bus.block_valid) m_bidx = bus.block_id;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("rs_model", bus.rs, m_pack(0));
        check("rt_model", bus.rt, m_pack(1));
        check("busy_model", 64'(bus.clear_busy), 64'(m_left > 0));
        check("err_model", 64'(bus.ro_write_err), 64'(m_err));
    endtask

    task automatic drive_idle();
        bus.core_state               = 3'b000;
        bus.decoded_reg_write_enable = 1'b0;
        bus.clear_start              = 1'b0;
        bus.block_valid              = 1'b0;
    endtask

    task automatic wait_sweep();
        int g;
        g = 0;
        while (bus.clear_busy && g < 60) begin
            tick();
            g++;
        end
        check("sweep_end", 64'(bus.clear_busy), 64'd0);
    endtask

    task automatic fill_const();
        for (int a = 0; a < GP; a++) begin
            bus.enable_mask = 4'hF; bus.core_state = UPD; bus.decoded_reg_write_enable = 1'b1;
            bus.decoded_reg_input_mux = 3'b010; bus.decoded_rd_address = 4'(a);
            bus.decoded_immediate = 8'(a + 1);
            tick();
        end
        drive_idle();
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [2:0]  cs;
        logic        we;
        logic [2:0]  mux;
        logic [3:0]  rd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [7:0]  imm;
        logic [63:0] ers;
        logic [63:0] ert;
        logic        eerr;
    } vec_t;

    vec_t tbl [8];

    logic [63:0] exp_w [5];
    logic [63:0] saved_rs;
    int          n;
    int          g;

    initial begin
        tbl[0] = '{4'hF, REQ,    1'b0, 3'b000, 4'd0,  4'd15, 4'd14, 8'h00,
                   64'h0003_0002_0001_0000, 64'h0004_0004_0004_0004, 1'b0};
        tbl[1] = '{4'h5, UPD,    1'b1, 3'b010, 4'd5,  4'd0,  4'd0,  8'h80,
                   64'h0003_0002_0001_0000, 64'h0004_0004_0004_0004, 1'b0};
        tbl[2] = '{4'hF, REQ,    1'b0, 3'b000, 4'd0,  4'd5,  4'd15, 8'h00,
                   64'h0000_FF80_0000_FF80, 64'h0003_0002_0001_0000, 1'b0};
        tbl[3] = '{4'hF, UPD,    1'b1, 3'b000, 4'd15, 4'd0,  4'd0,  8'h00,
                   64'h0000_FF80_0000_FF80, 64'h0003_0002_0001_0000, 1'b1};
        tbl[4] = '{4'hF, REQ,    1'b0, 3'b000, 4'd0,  4'd15, 4'd13, 8'h00,
                   64'h0003_0002_0001_0000, 64'h0000_0000_0000_0000, 1'b1};
        tbl[5] = '{4'hF, 3'b000, 1'b1, 3'b010, 4'd5,  4'd5,  4'd5,  8'h11,
                   64'h0003_0002_0001_0000, 64'h0000_0000_0000_0000, 1'b1};
        tbl[6] = '{4'h4, REQ,    1'b0, 3'b000, 4'd0,  4'd5,  4'd14, 8'h00,
                   64'h0003_FF80_0001_0000, 64'h0000_0004_0000_0000, 1'b1};
        tbl[7] = '{4'h0, UPD,    1'b1, 3'b000, 4'd14, 4'd0,  4'd0,  8'h00,
                   64'h0003_FF80_0001_0000, 64'h0000_0004_0000_0000, 1'b1};

        drive_idle();
        bus.enable_mask = 4'hF; bus.block_id = '0;
        bus.decoded_rd_address = '0; bus.decoded_rs_address = '0; bus.decoded_rt_address = '0;
        bus.decoded_reg_input_mux = '0; bus.decoded_immediate = '0;
        bus.alu_out = '0; bus.lsu_out = '0; bus.fma_out = '0; bus.act_out = '0;
        reset = 1'b0;
        #12;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_rs", bus.rs, 64'd0);
        check("reset_rt", bus.rt, 64'd0);
        check("reset_busy", 64'(bus.clear_busy), 64'd0);
        check("reset_err", 64'(bus.ro_write_err), 64'd0);

        for (int r = 0; r < 8; r++) begin
            bus.enable_mask = tbl[r].mask; bus.core_state = tbl[r].cs;
            bus.decoded_reg_write_enable = tbl[r].we; bus.decoded_reg_input_mux = tbl[r].mux;
            bus.decoded_rd_address = tbl[r].rd; bus.decoded_rs_address = tbl[r].ra;
            bus.decoded_rt_address = tbl[r].rb; bus.decoded_immediate = tbl[r].imm;
            tick();
            check("tbl_rs", bus.rs, tbl[r].ers);
            check("tbl_rt", bus.rt, tbl[r].ert);
            check("tbl_err", 64'(bus.ro_write_err), 64'(tbl[r].eerr));
            check("tbl_busy", 64'(bus.clear_busy), 64'd0);
        end
        drive_idle();
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        wait_sweep();

        // Per-lane sources: ALU, MEM, FMA, ACT, then the undefined select 3'b111 (ALU).
        for (int k = 0; k < 5; k++) begin
            bus.alu_out = {$urandom, $urandom}; bus.lsu_out = {$urandom, $urandom};
            bus.fma_out = {$urandom, $urandom}; bus.act_out = {$urandom, $urandom};
            bus.enable_mask = 4'hF; bus.core_state = UPD; bus.decoded_reg_write_enable = 1'b1;
            bus.decoded_rd_address = 4'(k);
            case (k)
                0: begin bus.decoded_reg_input_mux = 3'b000; exp_w[k] = bus.alu_out; end
                1: begin bus.decoded_reg_input_mux = 3'b001; exp_w[k] = bus.lsu_out; end
                2: begin bus.decoded_reg_input_mux = 3'b011; exp_w[k] = bus.fma_out; end
                3: begin bus.decoded_reg_input_mux = 3'b100; exp_w[k] = bus.act_out; end
                default: begin bus.decoded_reg_input_mux = 3'b111; exp_w[k] = bus.alu_out; end
            endcase
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            bus.core_state = REQ; bus.decoded_reg_write_enable = 1'b0;
            bus.decoded_rs_address = 4'(k); bus.decoded_rt_address = 4'(k);
            tick();
            check("lane_src_rs", bus.rs, exp_w[k]);
            check("lane_src_rt", bus.rt, exp_w[k]);
        end

        bus.core_state = UPD; bus.decoded_reg_write_enable = 1'b1; bus.decoded_rd_address = 4'd15;
        tick();
        check("ro_err_set", 64'(bus.ro_write_err), 64'd1);
        bus.core_state = REQ; bus.decoded_reg_write_enable = 1'b0;
        bus.decoded_rs_address = 4'd15; bus.decoded_rt_address = 4'd15;
        tick();
        check("tidx_intact", bus.rs, 64'h0003_0002_0001_0000);
        drive_idle();
        for (int k = 0; k < 3; k++) tick();
        check("ro_err_sticky", 64'(bus.ro_write_err), 64'd1);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        check("ro_err_cleared", 64'(bus.ro_write_err), 64'd0);
        wait_sweep();

        fill_const();
        bus.block_valid = 1'b1; bus.block_id = 8'h5C;
        tick();
        bus.block_valid = 1'b0;
        bus.core_state = REQ; bus.decoded_rs_address = 4'd7; bus.decoded_rt_address = 4'd13;
        tick();
        drive_idle();
        saved_rs = bus.rs;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        n = bus.clear_busy ? 1 : 0;
        g = 0;
        while (bus.clear_busy && g < 60) begin
            bus.core_state = REQ; bus.decoded_rs_address = 4'($urandom_range(0, GP-1));
            tick();
            if (bus.clear_busy) n++;
            g++;
        end
        check("sweep_len", 64'(n), 64'(GP));
        check("sweep_rs_hold", bus.rs, saved_rs);
        for (int a = 0; a < GP; a++) begin
            bus.core_state = REQ; bus.decoded_rs_address = 4'(a); bus.decoded_rt_address = 4'd13;
            tick();
            check("cleared_gpr", bus.rs, 64'd0);
            check("bidx_kept", bus.rt, 64'h005C_005C_005C_005C);
        end
        drive_idle();

        for (int c = 0; c < 400; c++) begin
            int sel;
            sel = $urandom_range(0, 3);
            bus.core_state = (sel == 1) ? UPD : (sel == 3) ? 3'($urandom) : REQ;
            bus.enable_mask = 4'($urandom);
            bus.decoded_reg_write_enable = ($urandom_range(0, 3) != 0);
            bus.decoded_reg_input_mux = 3'($urandom);
            bus.decoded_rd_address = 4'($urandom); bus.decoded_rs_address = 4'($urandom);
            bus.decoded_rt_address = 4'($urandom); bus.decoded_immediate = 8'($urandom);
            bus.alu_out = {$urandom, $urandom}; bus.lsu_out = {$urandom, $urandom};
            bus.fma_out = {$urandom, $urandom}; bus.act_out = {$urandom, $urandom};
            bus.clear_start = ($urandom_range(0, 49) == 0);
            bus.block_valid = ($urandom_range(0, 9) == 0);
            bus.block_id = 8'($urandom);
            tick();
        end
        drive_idle();
        wait_sweep();

        fill_const();
        bus.block_valid = 1'b1; bus.block_id = 8'h2A; bus.clear_start = 1'b1;
        tick();
        drive_idle();
        for (int k = 0; k < 5; k++) tick();
        check("midsweep_busy", 64'(bus.clear_busy), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check("async_busy_drop", 64'(bus.clear_busy), 64'd0);
        check("async_rs_zero", bus.rs, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.enable_mask = 4'hF;
        bus.core_state = REQ; bus.decoded_rs_address = 4'd13; bus.decoded_rt_address = 4'd14;
        tick();
        check("reset_bidx", bus.rs, 64'd0);
        check("reset_bdim", bus.rt, 64'h0004_0004_0004_0004);
        for (int a = 0; a < GP; a++) begin
            bus.core_state = REQ; bus.decoded_rs_address = 4'(a); bus.decoded_rt_address = 4'(a);
            tick();
            check("reset_gpr", bus.rs, 64'd0);
        end
        drive_idle();
        tick();
        check("reset_idle", 64'(bus.clear_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
